// File: rtl/updown_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module   : updown_sweep_pkg
// Purpose  : Shared types and default sizes for the up/down sweep sequencer.
//            Holds the sequencer state encoding and the default counter,
//            loop-count and dwell-count widths.
// Ports    : none (package)
// Options  : SWEEP_DWELL_EN (consumed by the sequencer, not by this package)
// Revision : 1.0 - initial release
// ============================================================================
package updown_sweep_pkg;

  localparam int DEFAULT_WIDTH   = 16;
  localparam int DEFAULT_LOOP_W  = 8;
  localparam int DEFAULT_DWELL_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    UP   = 3'd2,
    DOWN = 3'd3,
    DONE = 3'd4
  } sweep_state_t;

endpackage
`default_nettype wire

// File: rtl/updown_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : updown_sweep_ctrl_if
// Purpose  : Bundles the host-side control/status signals and the external
//            counter pins of the sweep sequencer.
// Ports    : host side   - start, abort, cfg_lo, cfg_hi, cfg_loops,
//                          cfg_dwell (SWEEP_DWELL_EN only), busy, done, err
//            counter side- cnt_ld_, cnt_updn, cnt_enb, cnt_data_in,
//                          cnt_data_out
//            modport slave  : the sequencer
//            modport master : host plus counter environment
// Options  : SWEEP_DWELL_EN adds cfg_dwell
// Revision : 1.0 - initial release
// ============================================================================
interface updown_sweep_ctrl_if
  import updown_sweep_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int LOOP_W  = DEFAULT_LOOP_W,
  parameter int DWELL_W = DEFAULT_DWELL_W
) ();

  logic              start;
  logic              abort;
  logic [WIDTH-1:0]  cfg_lo;
  logic [WIDTH-1:0]  cfg_hi;
  logic [LOOP_W-1:0] cfg_loops;
`ifdef SWEEP_DWELL_EN
  logic [DWELL_W-1:0] cfg_dwell;
`endif
  logic              busy;
  logic              done;
  logic              err;
  logic              cnt_ld_;
  logic              cnt_updn;
  logic              cnt_enb;
  logic [WIDTH-1:0]  cnt_data_in;
  logic [WIDTH-1:0]  cnt_data_out;

  modport slave (
`ifdef SWEEP_DWELL_EN
    input  cfg_dwell,
`endif
    input  start, abort, cfg_lo, cfg_hi, cfg_loops, cnt_data_out,
    output busy, done, err, cnt_ld_, cnt_updn, cnt_enb, cnt_data_in
  );

  modport master (
`ifdef SWEEP_DWELL_EN
    output cfg_dwell,
`endif
    output start, abort, cfg_lo, cfg_hi, cfg_loops, cnt_data_out,
    input  busy, done, err, cnt_ld_, cnt_updn, cnt_enb, cnt_data_in
  );

endinterface
`default_nettype wire

// File: rtl/sweep_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module   : sweep_dwell_timer
// Purpose  : Down-counter that measures the extra hold cycles spent at each
//            sweep turnaround. Reloads whenever load is high, counts down
//            while dec is high, and saturates at zero.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            load, load_val  - reload strobe and value
//            dec             - decrement request
//            zero            - count has reached zero
// Options  : instantiated only when SWEEP_DWELL_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
module sweep_dwell_timer
  import updown_sweep_pkg::*;
#(
  parameter int DWELL_W = DEFAULT_DWELL_W
) (
  input  wire               clk,
  input  wire               rst,
  input  wire               load,
  input  wire [DWELL_W-1:0] load_val,
  input  wire               dec,
  output logic              zero
);

  logic [DWELL_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/updown_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : updown_sweep_ctrl
// Purpose  : Drives an external 16-bit up/down counter through triangular
//            sweeps: load floor, count up to ceiling, count back to floor,
//            repeat for the programmed number of loops, then pulse done.
// Ports    : clk, rst - clock, synchronous active-high reset
//            bus      - updown_sweep_ctrl_if.slave (host control/status and
//                       counter ld_/updn/enb/data_in/data_out pins)
// Options  : SWEEP_DWELL_EN - adds cfg_dwell; each turnaround holds for
//                             1+dwell cycles instead of 1
// Revision : 1.0 - initial release
// ============================================================================
module updown_sweep_ctrl
  import updown_sweep_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int LOOP_W  = DEFAULT_LOOP_W,
  parameter int DWELL_W = DEFAULT_DWELL_W
) (
  input  wire                clk,
  input  wire                rst,
  updown_sweep_ctrl_if.slave bus
);

  sweep_state_t      state;
  logic [WIDTH-1:0]  lo_q;
  logic [WIDTH-1:0]  hi_q;
  logic [LOOP_W-1:0] loops_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              ld_n_q;
  logic              updn_q;

  logic at_hi;
  logic at_lo;
  logic cfg_ok;
  logic turn;
  logic dwell_done;
  logic enb;

  assign at_hi  = (bus.cnt_data_out == hi_q);
  assign at_lo  = (bus.cnt_data_out == lo_q);
  assign cfg_ok = (bus.cfg_lo < bus.cfg_hi) && (bus.cfg_loops != '0);

  // Sitting at the end point of the current direction.
  assign turn = ((state == UP) && at_hi) || ((state == DOWN) && at_lo);

  // Enable stops exactly at the end points so the counter never wraps.
  // Abort and reset kill the step in the same cycle they are presented.
  always_comb begin
    enb = 1'b0;
    if (!rst && !bus.abort) begin
      if (state == UP) begin
        enb = !at_hi;
      end else if (state == DOWN) begin
        enb = !at_lo;
      end
    end
  end

`ifdef SWEEP_DWELL_EN
  logic [DWELL_W-1:0] dwell_q;
  logic               dwell_zero;

  // The timer reloads on every non-turnaround cycle, so it always holds
  // dwell_q on the first turnaround cycle and counts down from there.
  sweep_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (!turn),
    .load_val (dwell_q),
    .dec      (turn),
    .zero     (dwell_zero)
  );

  assign dwell_done = dwell_zero;
`else
  assign dwell_done = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      loops_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ld_n_q  <= 1'b1;
      updn_q  <= 1'b1;
`ifdef SWEEP_DWELL_EN
      dwell_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      ld_n_q <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (cfg_ok) begin
              lo_q    <= bus.cfg_lo;
              hi_q    <= bus.cfg_hi;
              loops_q <= bus.cfg_loops;
`ifdef SWEEP_DWELL_EN
              dwell_q <= bus.cfg_dwell;
`endif
              state   <= LOAD;
              busy_q  <= 1'b1;
              ld_n_q  <= 1'b0;
              updn_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            state  <= UP;
            updn_q <= 1'b1;
          end
        end
        UP: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (at_hi && dwell_done) begin
            state  <= DOWN;
            updn_q <= 1'b0;
          end
        end
        DOWN: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (at_lo && dwell_done) begin
            if (loops_q == LOOP_W'(1)) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              loops_q <= loops_q - 1'b1;
              state   <= UP;
              updn_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.cnt_ld_     = ld_n_q;
  assign bus.cnt_updn    = updn_q;
  assign bus.cnt_enb     = enb;
  assign bus.cnt_data_in = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_updown_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_updown_sweep_ctrl
// Purpose  : Testbench for updown_sweep_ctrl. Models the external counter,
//            queues expected LOAD/DONE/ERR events as sweeps are issued and
//            compares them in a separate monitor process.
// Options  : SWEEP_DWELL_EN enables the dwell scenario
// Revision : 1.0 - initial release
// ============================================================================
module tb_updown_sweep_ctrl;

  localparam int EV_LOAD = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  typedef struct {
    int kind;
    int cyc;
    int lo;
    int hi;
    int idle;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   wrap_cnt;

  ev_t         sb[$];
  logic [15:0] cnt_model;
  logic [15:0] max_seen;
  logic [15:0] min_seen;
  int          idle_cnt;

  updown_sweep_ctrl_if bus ();

  updown_sweep_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External counter: load has priority over counting.
  initial begin
    cnt_model = 16'h0000;
    wrap_cnt  = 0;
  end
  always @(posedge clk) begin
    if (!bus.cnt_ld_) begin
      cnt_model <= bus.cnt_data_in;
    end else if (bus.cnt_enb) begin
      if (bus.cnt_updn && cnt_model == 16'hFFFF) wrap_cnt++;
      if (!bus.cnt_updn && cnt_model == 16'h0000) wrap_cnt++;
      cnt_model <= bus.cnt_updn ? cnt_model + 16'd1 : cnt_model - 16'd1;
    end
  end
  assign bus.cnt_data_out = cnt_model;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_event(input int kind);
    ev_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
    end else begin
      e = sb.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.cyc);
      if (kind == EV_DONE && e.kind == EV_DONE) begin
        check("done_cnt_value", bus.cnt_data_out, e.lo);
        check("sweep_max", max_seen, e.hi);
        check("sweep_min", min_seen, e.lo);
        check("turnaround_idle_cycles", idle_cnt, e.idle);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    max_seen = 16'h0000;
    min_seen = 16'hFFFF;
    idle_cnt = 0;
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy && bus.cnt_ld_) begin
        if (bus.cnt_data_out > max_seen) max_seen = bus.cnt_data_out;
        if (bus.cnt_data_out < min_seen) min_seen = bus.cnt_data_out;
        if (!bus.cnt_enb) idle_cnt++;
      end
      if (!bus.cnt_ld_) begin
        expect_event(EV_LOAD);
        max_seen = 16'h0000;
        min_seen = 16'hFFFF;
        idle_cnt = 0;
      end
      if (bus.done) expect_event(EV_DONE);
      if (bus.err) expect_event(EV_ERR);
    end
  end

  // Issue one start and queue the expected responses. Returns the cycle in
  // which LOAD (or err) is expected; the task ends in that cycle.
  task automatic issue(input logic [15:0] lo, input logic [15:0] hi, input logic [7:0] loops,
                       input int dwell, input bit expect_done, output int load_cyc);
    ev_t e;
    int  d;
    @(posedge clk); #1;
    bus.cfg_lo    = lo;
    bus.cfg_hi    = hi;
    bus.cfg_loops = loops;
`ifdef SWEEP_DWELL_EN
    bus.cfg_dwell = dwell[7:0];
`endif
    bus.start     = 1'b1;
    load_cyc      = cyc + 1;
    if (lo < hi && loops != 8'd0) begin
      d = int'(hi) - int'(lo);
      e = '{kind: EV_LOAD, cyc: load_cyc, lo: 0, hi: 0, idle: 0};
      sb.push_back(e);
      if (expect_done) begin
        e = '{kind: EV_DONE,
              cyc: load_cyc + 1 + int'(loops) * (2 * d + 2 + 2 * dwell),
              lo: int'(lo), hi: int'(hi), idle: 2 * int'(loops) * (1 + dwell)};
        sb.push_back(e);
      end
    end else begin
      e = '{kind: EV_ERR, cyc: load_cyc, lo: 0, hi: 0, idle: 0};
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    for (int n = 0; n < 2000 && cyc < target; n++) begin
      @(posedge clk); #1;
    end
    check("reached_cycle", cyc, target);
  endtask

  int          lc;
  logic [15:0] held;

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.cfg_lo    = '0;
    bus.cfg_hi    = '0;
    bus.cfg_loops = '0;
`ifdef SWEEP_DWELL_EN
    bus.cfg_dwell = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_cnt_ld_", bus.cnt_ld_, 1);
    check("rst_cnt_updn", bus.cnt_updn, 1);
    check("rst_cnt_enb", bus.cnt_enb, 0);
    check("rst_cnt_data_in", bus.cnt_data_in, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic two-loop sweep; a start with new config mid-sweep is ignored.
    issue(16'h0010, 16'h0014, 8'd2, 0, 1'b1, lc);
    repeat (3) @(posedge clk);
    #1;
    bus.cfg_lo    = 16'h0000;
    bus.cfg_hi    = 16'h0100;
    bus.cfg_loops = 8'd9;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    drain(500);

    // Rejected starts: lo > hi, lo == hi, loops == 0.
    issue(16'h0014, 16'h0010, 8'd2, 0, 1'b1, lc);
    @(negedge clk);
    check("err_busy_low", bus.busy, 0);
    check("err_cnt_ld_high", bus.cnt_ld_, 1);
    drain(50);
    issue(16'h0005, 16'h0005, 8'd1, 0, 1'b1, lc);
    drain(50);
    issue(16'h0010, 16'h0014, 8'd0, 0, 1'b1, lc);
    @(negedge clk);
    check("err_loops0_busy_low", bus.busy, 0);
    drain(50);

    // Boundaries: top of range and bottom of range.
    issue(16'hFFF0, 16'hFFFF, 8'd1, 0, 1'b1, lc);
    drain(500);
    issue(16'h0000, 16'h000F, 8'd2, 0, 1'b1, lc);
    drain(500);

    // Abort in the second UP phase, then a fresh sweep.
    issue(16'h0020, 16'h0024, 8'd3, 0, 1'b0, lc);
    wait_cyc(lc + 12);
    bus.abort = 1'b1;
    @(negedge clk);
    check("abort_cnt_value", bus.cnt_data_out, 16'h0021);
    check("abort_enb_low", bus.cnt_enb, 0);
    held = bus.cnt_data_out;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort_busy_low", bus.busy, 0);
    check("abort_cnt_held", bus.cnt_data_out, held);
    repeat (3) @(negedge clk);
    check("abort_cnt_still_held", bus.cnt_data_out, held);
    drain(50);
    issue(16'h0040, 16'h0042, 8'd1, 0, 1'b1, lc);
    drain(200);

    // Reset in the middle of the DOWN phase.
    issue(16'h0030, 16'h0038, 8'd1, 0, 1'b0, lc);
    drain(50);
    wait_cyc(lc + 12);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_cnt_value", bus.cnt_data_out, 16'h0036);
    held = bus.cnt_data_out;
    @(negedge clk);
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_done", bus.done, 0);
    check("rstmid_err", bus.err, 0);
    check("rstmid_cnt_ld_", bus.cnt_ld_, 1);
    check("rstmid_cnt_updn", bus.cnt_updn, 1);
    check("rstmid_cnt_enb", bus.cnt_enb, 0);
    check("rstmid_cnt_data_in", bus.cnt_data_in, 0);
    check("rstmid_no_step", bus.cnt_data_out, held);
    @(posedge clk); #1;
    rst = 1'b0;
    issue(16'h0001, 16'h0003, 8'd2, 0, 1'b1, lc);
    drain(200);

`ifdef SWEEP_DWELL_EN
    // Dwell of 3: four enable-low cycles at each turnaround.
    issue(16'h0000, 16'h0002, 8'd1, 3, 1'b1, lc);
    drain(200);
    issue(16'h0010, 16'h0013, 8'd2, 1, 1'b1, lc);
    drain(200);
`endif

    check("no_counter_wrap", wrap_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
